ctrl_fsm: RTL and testbench

CTRL_FSM -- requirements
Module: ctrl_fsm

---
 rtl/ctrl_pkg.sv | 55 +++++
 rtl/ack_timer.sv | 27 ++
 rtl/ctrl_fsm.sv | 187 ++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode, pc_src and instruction-class definitions for ctrl_fsm
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;  // pc + 4
    localparam logic [1:0] PC_SRC_REL = 2'd1;  // pc + imm
    localparam logic [1:0] PC_SRC_REG = 2'd2;  // rs1 + imm

    typedef enum logic [2:0] {
        CL_BRANCH,
        CL_LOAD,
        CL_STORE,
        CL_ALU_REG,
        CL_ALU_IMM,
        CL_JAL,
        CL_JALR,
        CL_ILLEGAL
    } op_class_t;

    // Collapse opcode/funct3 into the handful of sequencing classes the FSM cares about.
    // Load funct3 of 3, 6 or 7 and store funct3 above 2 classify as illegal.
    function automatic op_class_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
        op_class_t c;
        case (opcode)
            OP_BRANCH:                c = CL_BRANCH;
            OP_LOAD:                  c = (funct3 == 3'd3 || funct3 >= 3'd6) ? CL_ILLEGAL : CL_LOAD;
            OP_STORE:                 c = (funct3 > 3'd2) ? CL_ILLEGAL : CL_STORE;
            OP_OP:                    c = CL_ALU_REG;
            OP_IMM, OP_LUI, OP_AUIPC: c = CL_ALU_IMM;
            OP_JAL:                   c = CL_JAL;
            OP_JALR:                  c = CL_JALR;
            default:                  c = CL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ack_timer.sv
// rtl/ack_timer.sv - saturating wait counter used to bound fetch and memory acknowledge waits
module ack_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] r_count;

    // Count ack-low cycles; hold at the limit so a wait that is allowed to continue never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (enable && !expired) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expired = (r_count == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle instruction sequencer; define CTRL_FSM_TRAP_EN to trap on illegal encodings and ack timeouts
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        br_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_b_imm,
    output logic        retire,
    output logic [31:0] instret,
    output logic [2:0]  state,
    output logic        fault
);

`ifdef CTRL_FSM_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t      r_state;
    op_class_t   r_cls;
    logic [31:0] r_instret;
    logic        r_fault;

    op_class_t   w_cls;
    logic        w_in_wait;
    logic        w_ack;
    logic        w_expired;
    logic        w_timeout;

    assign w_cls     = classify(opcode, funct3);
    assign w_in_wait = (r_state == ST_FETCH) || (r_state == ST_MEM);
    // Only the ack belonging to the current wait state is honoured
    assign w_ack     = ((r_state == ST_FETCH) && imem_ack) || ((r_state == ST_MEM) && dmem_ack);
    // An ack in the very cycle the limit is reached still wins over the timeout
    assign w_timeout = TRAP_EN && w_in_wait && !w_ack && w_expired;

    // Timer is held clear outside the wait states, so it starts from zero on every entry
    ack_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_in_wait || w_ack),
        .enable  (w_in_wait && !w_ack),
        .expired (w_expired)
    );

    // Strobes decoded from the registered state plus live inputs; all forced low during reset
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_SEQ;
        alu_b_imm = 1'b0;
        retire    = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                ST_EXEC: begin
                    case (w_cls)
                        CL_BRANCH: begin
                            pc_we  = 1'b1;
                            pc_src = br_taken ? PC_SRC_REL : PC_SRC_SEQ;
                            retire = 1'b1;
                        end
                        CL_LOAD, CL_STORE, CL_ALU_IMM, CL_JAL, CL_JALR: begin
                            alu_b_imm = 1'b1;
                        end
                        CL_ALU_REG: begin
                        end
                        default: begin
                            // Without trapping, an illegal encoding simply retires as a NOP
                            pc_we  = !TRAP_EN;
                            retire = !TRAP_EN;
                        end
                    endcase
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (r_cls == CL_STORE);
                    if (dmem_ack && r_cls == CL_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                ST_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    if (r_cls == CL_JAL) begin
                        pc_src = PC_SRC_REL;
                    end else if (r_cls == CL_JALR) begin
                        pc_src = PC_SRC_REG;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sequencer state, latched instruction class, retired count and sticky fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_cls     <= CL_ILLEGAL;
            r_instret <= 32'd0;
            r_fault   <= 1'b0;
        end else begin
            if (retire) begin
                r_instret <= r_instret + 32'd1;
            end
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_state <= ST_DECODE;
                    end else if (w_timeout) begin
                        r_state <= ST_TRAP;
                        r_fault <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_cls <= w_cls;
                    case (w_cls)
                        CL_BRANCH:                               r_state <= ST_FETCH;
                        CL_LOAD, CL_STORE:                       r_state <= ST_MEM;
                        CL_ALU_REG, CL_ALU_IMM, CL_JAL, CL_JALR: r_state <= ST_WB;
                        default: begin
                            if (TRAP_EN) begin
                                r_state <= ST_TRAP;
                                r_fault <= 1'b1;
                            end else begin
                                r_state <= ST_FETCH;
                            end
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        r_state <= (r_cls == CL_LOAD) ? ST_WB : ST_FETCH;
                    end else if (w_timeout) begin
                        r_state <= ST_TRAP;
                        r_fault <= 1'b1;
                    end
                end
                ST_WB: begin
                    r_state <= ST_FETCH;
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign instret = r_instret;
    assign state   = r_state;
    assign fault   = r_fault;

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - self-checking bench for ctrl_fsm: vector table, corner sequences, randomized instructions
module tb_ctrl_fsm;

    localparam int TMO = 4;
`ifdef CTRL_FSM_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int K_BR = 0, K_LD = 1, K_ST = 2, K_OP = 3, K_IMM = 4, K_JAL = 5, K_JALR = 6, K_ILL = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        br_taken = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, alu_b_imm, retire, fault;
    logic [1:0]  pc_src;
    logic [31:0] instret;
    logic [2:0]  state;

    ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_b_imm(alu_b_imm), .retire(retire), .instret(instret), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       rf_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_b_imm;
        logic       retire;
        logic       fault;
    } obs_t;

    typedef struct packed {
        logic ia;
        logic da;
        obs_t e;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       br;
        int         id;
        int         dd;
        int         ncyc;
        int         nrf;
        int         ndreq;
        int         nret;
    } vec_t;

    cyc_t tr[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cnt = 0;
    bit   m_trapped = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.imem_req = imem_req; o.ir_we = ir_we; o.dmem_req = dmem_req;
        o.dmem_we = dmem_we; o.rf_we = rf_we; o.pc_we = pc_we; o.pc_src = pc_src;
        o.alu_b_imm = alu_b_imm; o.retire = retire; o.fault = fault;
        return o;
    endfunction

    function automatic obs_t mk(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic int kind(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b1100011: return K_BR;
            7'b0000011: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? K_ILL : K_LD;
            7'b0100011: return (f3 <= 3'd2) ? K_ST : K_ILL;
            7'b0110011: return K_OP;
            7'b0010011, 7'b0110111, 7'b0010111: return K_IMM;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            default: return K_ILL;
        endcase
    endfunction

    task automatic push(input obs_t e, input logic ia, input logic da);
        cyc_t c;
        c.ia = ia; c.da = da; c.e = e;
        tr.push_back(c);
    endtask

    task automatic push_wb(input logic [1:0] src);
        obs_t e;
        e = mk(3'd4); e.rf_we = 1'b1; e.pc_we = 1'b1; e.pc_src = src; e.retire = 1'b1;
        push(e, rb(), rb());
    endtask

    // Expected cycle-by-cycle trace of one instruction, derived from the sequencing rules;
    // acks that do not belong to the current wait are randomized and must be ignored
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic br, input int id, input int dd);
        obs_t e;
        int   k;
        bit   trap;
        trap = 1'b0;
        tr.delete();
        for (int i = 0; i <= id; i++) begin
            e = mk(3'd0); e.imem_req = 1'b1; e.ir_we = (i == id);
            push(e, (i == id), rb());
            if (TRAP_EN && i < id && i == TMO) begin
                trap = 1'b1;
                break;
            end
        end
        if (!trap) begin
            push(mk(3'd1), rb(), rb());
            k = kind(op, f3);
            e = mk(3'd2);
            case (k)
                K_BR: begin
                    e.pc_we = 1'b1; e.pc_src = br ? 2'd1 : 2'd0; e.retire = 1'b1;
                    push(e, rb(), rb());
                end
                K_LD, K_ST: begin
                    e.alu_b_imm = 1'b1;
                    push(e, rb(), rb());
                    for (int i = 0; i <= dd; i++) begin
                        e = mk(3'd3); e.dmem_req = 1'b1; e.dmem_we = (k == K_ST);
                        if (i == dd && k == K_ST) begin
                            e.pc_we = 1'b1; e.retire = 1'b1;
                        end
                        push(e, rb(), (i == dd));
                        if (TRAP_EN && i < dd && i == TMO) begin
                            trap = 1'b1;
                            break;
                        end
                    end
                    if (!trap && k == K_LD) push_wb(2'd0);
                end
                K_OP: begin
                    push(e, rb(), rb());
                    push_wb(2'd0);
                end
                K_IMM, K_JAL, K_JALR: begin
                    e.alu_b_imm = 1'b1;
                    push(e, rb(), rb());
                    push_wb((k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0);
                end
                default: begin
                    if (TRAP_EN) begin
                        trap = 1'b1;
                    end else begin
                        e.pc_we = 1'b1; e.retire = 1'b1;
                    end
                    push(e, rb(), rb());
                end
            endcase
        end
        if (trap) begin
            for (int i = 0; i < 3; i++) begin
                e = mk(3'd5); e.fault = 1'b1;
                push(e, rb(), rb());
            end
        end
        m_trapped = trap;
    endtask

    // Drive the trace from just after a rising edge, compare at the falling edge
    task automatic apply(input int limit, output int ncyc, output int nrf, output int ndreq, output int nret);
        obs_t got;
        ncyc = 0; nrf = 0; ndreq = 0; nret = 0;
        for (int i = 0; i < tr.size() && i < limit; i++) begin
            imem_ack = tr[i].ia;
            dmem_ack = tr[i].da;
            @(negedge clk);
            got = sample();
            chk($sformatf("cycle%0d outputs", i), 64'(got), 64'(tr[i].e));
            chk($sformatf("cycle%0d instret", i), 64'(instret), 64'(m_cnt));
            if (got.st != 3'd5) ncyc++;
            if (got.rf_we) nrf++;
            if (got.dmem_req) ndreq++;
            if (got.retire) nret++;
            if (tr[i].e.retire) m_cnt++;
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic br, input int id, input int dd,
                       input int limit, output int ncyc, output int nrf, output int ndreq, output int nret);
        opcode = op; funct3 = f3; br_taken = br;
        build(op, f3, br, id, dd);
        apply(limit, ncyc, nrf, ndreq, nret);
    endtask

    task automatic do_reset();
        obs_t z;
        z = '0;
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        chk("reset outputs", 64'(sample()), 64'(z));
        chk("reset instret", 64'(instret), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cnt = 0;
        m_trapped = 1'b0;
    endtask

    vec_t vecs[15];
    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F};

    initial begin
        int nc, nr, nd, nt;
        obs_t z;
        logic [6:0] op;
        z = '0;

        vecs[0]  = '{7'h33, 3'd0, 1'b0, 2, 0, 6, 1, 0, 1};
        vecs[1]  = '{7'h63, 3'd0, 1'b1, 0, 0, 3, 0, 0, 1};
        vecs[2]  = '{7'h03, 3'd2, 1'b0, 0, 3, 8, 1, 4, 1};
        vecs[3]  = '{7'h23, 3'd2, 1'b0, 1, 0, 5, 0, 1, 1};
        vecs[4]  = '{7'h6F, 3'd0, 1'b0, 0, 0, 4, 1, 0, 1};
        vecs[5]  = '{7'h67, 3'd0, 1'b0, 0, 0, 4, 1, 0, 1};
        vecs[6]  = '{7'h37, 3'd0, 1'b0, 1, 0, 5, 1, 0, 1};
        vecs[7]  = '{7'h63, 3'd1, 1'b0, 0, 0, 3, 0, 0, 1};
        vecs[8]  = '{7'h33, 3'd0, 1'b0, TMO, 0, 8, 1, 0, 1};
        vecs[9]  = '{7'h03, 3'd0, 1'b0, 0, TMO, 9, 1, 5, 1};
`ifdef CTRL_FSM_TRAP_EN
        vecs[10] = '{7'h7F, 3'd0, 1'b0, 0, 0, 3, 0, 0, 0};
        vecs[11] = '{7'h03, 3'd3, 1'b0, 0, 0, 3, 0, 0, 0};
        vecs[12] = '{7'h33, 3'd0, 1'b0, 6, 0, 5, 0, 0, 0};
        vecs[13] = '{7'h23, 3'd2, 1'b0, 0, 6, 8, 0, 5, 0};
        vecs[14] = '{7'h23, 3'd3, 1'b0, 0, 0, 3, 0, 0, 0};
`else
        vecs[10] = '{7'h7F, 3'd0, 1'b0, 0, 0, 3, 0, 0, 1};
        vecs[11] = '{7'h03, 3'd3, 1'b0, 0, 0, 3, 0, 0, 1};
        vecs[12] = '{7'h33, 3'd0, 1'b0, 6, 0, 10, 1, 0, 1};
        vecs[13] = '{7'h23, 3'd2, 1'b0, 0, 6, 10, 0, 7, 1};
        vecs[14] = '{7'h23, 3'd3, 1'b0, 0, 0, 3, 0, 0, 1};
`endif

        do_reset();

        foreach (vecs[v]) begin
            run(vecs[v].op, vecs[v].f3, vecs[v].br, vecs[v].id, vecs[v].dd, 1000, nc, nr, nd, nt);
            chk($sformatf("vec%0d cycles", v), 64'(nc), 64'(vecs[v].ncyc));
            chk($sformatf("vec%0d rf_we", v), 64'(nr), 64'(vecs[v].nrf));
            chk($sformatf("vec%0d dmem_req", v), 64'(nd), 64'(vecs[v].ndreq));
            chk($sformatf("vec%0d retire", v), 64'(nt), 64'(vecs[v].nret));
            if (m_trapped) do_reset();
        end

        // Reset during a load's memory wait abandons it; fetch resumes right after release
        run(7'h03, 3'd2, 1'b0, 0, 5, 5, nc, nr, nd, nt);
        dmem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid-mem reset outputs", 64'(sample()), 64'(z));
        chk("mid-mem reset instret", 64'(instret), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cnt = 0;
        run(7'h33, 3'd0, 1'b0, 1, 0, 1000, nc, nr, nd, nt);
        chk("post-reset add retire", 64'(nt), 64'd1);

        for (int r = 0; r < 40; r++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            run(op, 3'($urandom), rb(), $urandom_range(0, TMO + 2), $urandom_range(0, TMO + 2),
                1000, nc, nr, nd, nt);
            if (m_trapped) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
